// File: rtl/lsu_mem_master.sv
// lsu_mem_master
// Load/store master between the execute stage and the cache/memory block.
// Accepts one request at a time, checks RISC-V alignment, drives the memory
// valid/ready handshake, and returns load data or a classified error.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   core_req/we/addr/wdata/size/unsigned - request from the core (latched on accept)
//   core_busy           - high from acceptance through core_done
//   core_done           - one-cycle completion pulse
//   core_rdata/err/fault_addr - completion results, valid with core_done
//   mem_valid/rw/addr/data_in/byte_half_word/is_load_unsigned - memory request
//   mem_ready/out_of_range/data_out - memory response
module lsu_mem_master #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter bit          ALIGN_CHECK    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [1:0]  core_size,
    input  logic        core_unsigned,
    output logic        core_busy,
    output logic        core_done,
    output logic [31:0] core_rdata,
    output logic [1:0]  core_err,
    output logic [31:0] core_fault_addr,
    output logic        mem_valid,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    output logic [1:0]  mem_byte_half_word,
    output logic        mem_is_load_unsigned,
    input  logic        mem_ready,
    input  logic        mem_out_of_range,
    input  logic [31:0] mem_data_out
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CHECK   = 2'd1;
    localparam logic [1:0] S_ACCESS  = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_FAULT   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  err_q, err_d;
    logic [15:0] tmo_q, tmo_d;

    logic misaligned;
    logic tmo_hit;

    // Illegal size is rejected even when alignment checking is disabled.
    always_comb begin
        misaligned = (size_q == 2'b11);
        if (ALIGN_CHECK) begin
            if (size_q == 2'b00 && addr_q[1:0] != 2'b00) misaligned = 1'b1;
            if (size_q == 2'b01 && addr_q[0])            misaligned = 1'b1;
        end
    end

    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (core_req) begin
                    state_d = S_CHECK;
                    we_d    = core_we;
                    addr_d  = core_addr;
                    wdata_d = core_wdata;
                    size_d  = core_size;
                    uns_d   = core_unsigned;
                    rdata_d = '0;
                    err_d   = ERR_OK;
                end
            end
            S_CHECK: begin
                if (misaligned) begin
                    state_d = S_RELEASE;
                    err_d   = ERR_ALIGN;
                end else begin
                    state_d = S_ACCESS;
                    tmo_d   = '0;
                end
            end
            S_ACCESS: begin
                // out_of_range takes priority over a simultaneous ready.
                if (mem_out_of_range) begin
                    state_d = S_RELEASE;
                    err_d   = ERR_FAULT;
                end else if (mem_ready) begin
                    state_d = S_RELEASE;
                    err_d   = ERR_OK;
                    rdata_d = we_q ? '0 : mem_data_out;
                end else if (tmo_hit) begin
                    state_d = S_RELEASE;
                    err_d   = ERR_TIMEOUT;
                end else if (tmo_q != '1) begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    assign core_busy            = (state_q != S_IDLE);
    assign core_done            = (state_q == S_RELEASE);
    assign core_rdata           = rdata_q;
    assign core_err             = err_q;
    assign core_fault_addr      = addr_q;
    assign mem_valid            = (state_q == S_ACCESS);
    assign mem_rw               = we_q;
    assign mem_addr             = addr_q;
    assign mem_data_in          = wdata_q;
    assign mem_byte_half_word   = size_q;
    assign mem_is_load_unsigned = uns_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed testbench for lsu_mem_master. Instance u_a uses alignment checking
// with a 16-cycle timeout; instance u_b has alignment checking disabled.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we, core_unsigned;
    logic [31:0] core_addr, core_wdata;
    logic [1:0]  core_size;
    logic        sel;
    logic        mem_ready, mem_out_of_range;
    logic [31:0] mem_data_out;

    logic        busy_a, done_a, valid_a, rw_a, uns_a;
    logic [31:0] rdata_a, faddr_a, maddr_a, mdin_a;
    logic [1:0]  err_a, bhw_a;
    logic        busy_b, done_b, valid_b, rw_b, uns_b;
    logic [31:0] rdata_b, faddr_b, maddr_b, mdin_b;
    logic [1:0]  err_b, bhw_b;

    always #5 clk = ~clk;

    lsu_mem_master #(.TIMEOUT_CYCLES(16), .ALIGN_CHECK(1'b1)) u_a (
        .clk(clk), .rst(rst), .core_req(core_req & ~sel), .core_we(core_we),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_size(core_size),
        .core_unsigned(core_unsigned), .core_busy(busy_a), .core_done(done_a),
        .core_rdata(rdata_a), .core_err(err_a), .core_fault_addr(faddr_a),
        .mem_valid(valid_a), .mem_rw(rw_a), .mem_addr(maddr_a), .mem_data_in(mdin_a),
        .mem_byte_half_word(bhw_a), .mem_is_load_unsigned(uns_a),
        .mem_ready(mem_ready & ~sel), .mem_out_of_range(mem_out_of_range & ~sel),
        .mem_data_out(mem_data_out)
    );

    lsu_mem_master #(.ALIGN_CHECK(1'b0)) u_b (
        .clk(clk), .rst(rst), .core_req(core_req & sel), .core_we(core_we),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_size(core_size),
        .core_unsigned(core_unsigned), .core_busy(busy_b), .core_done(done_b),
        .core_rdata(rdata_b), .core_err(err_b), .core_fault_addr(faddr_b),
        .mem_valid(valid_b), .mem_rw(rw_b), .mem_addr(maddr_b), .mem_data_in(mdin_b),
        .mem_byte_half_word(bhw_b), .mem_is_load_unsigned(uns_b),
        .mem_ready(mem_ready & sel), .mem_out_of_range(mem_out_of_range & sel),
        .mem_data_out(mem_data_out)
    );

    // Outputs of the currently selected instance.
    logic        busy, done, valid, rw, uns;
    logic [31:0] rdata, faddr, maddr, mdin;
    logic [1:0]  err, bhw;
    assign busy  = sel ? busy_b  : busy_a;
    assign done  = sel ? done_b  : done_a;
    assign valid = sel ? valid_b : valid_a;
    assign rw    = sel ? rw_b    : rw_a;
    assign uns   = sel ? uns_b   : uns_a;
    assign rdata = sel ? rdata_b : rdata_a;
    assign faddr = sel ? faddr_b : faddr_a;
    assign maddr = sel ? maddr_b : maddr_a;
    assign mdin  = sel ? mdin_b  : mdin_a;
    assign err   = sel ? err_b   : err_a;
    assign bhw   = sel ? bhw_b   : bhw_a;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory model: mode 0 = ready after lat valid cycles, 1 = never respond,
    // 2 = out_of_range, 3 = out_of_range together with ready.
    int          mode = 0;
    int          lat  = 1;
    int          wcnt = 0;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_data = '0;
    logic [31:0] mem_arr [logic [29:0]];

    initial begin
        mem_ready = 1'b0; mem_out_of_range = 1'b0; mem_data_out = '0;
    end

    always @(negedge clk) begin
        mem_ready        = 1'b0;
        mem_out_of_range = 1'b0;
        mem_data_out     = '0;
        if (valid) begin
            wcnt++;
            if (mode == 0 && wcnt >= lat) begin
                mem_ready = 1'b1;
                if (rw) mem_arr[maddr[31:2]] = mdin;
                else if (ovr_en) mem_data_out = ovr_data;
                else if (mem_arr.exists(maddr[31:2])) mem_data_out = mem_arr[maddr[31:2]];
            end else if (mode == 2) begin
                mem_out_of_range = 1'b1;
            end else if (mode == 3) begin
                mem_out_of_range = 1'b1;
                mem_ready        = 1'b1;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Minimum valid-low gap between accesses and longest core_done run.
    int gap = 0, min_gap = 1000, done_run = 0, max_done_run = 0;
    logic seen_fall = 1'b0, prev_valid = 1'b0;
    always @(negedge clk) begin
        if (!valid) gap++;
        if (valid && !prev_valid && seen_fall && gap < min_gap) min_gap = gap;
        if (!valid && prev_valid) begin seen_fall = 1'b1; gap = 1; end
        prev_valid = valid;
        done_run = done ? done_run + 1 : 0;
        if (done_run > max_done_run) max_done_run = done_run;
    end

    logic [1:0]  r_err, r_bhw;
    logic [31:0] r_rdata, r_faddr;
    logic        r_uns;
    int          r_cyc, r_vc;

    // Issue one request and wait (bounded) for core_done; request inputs are
    // scrambled after acceptance to show that the DUT latched them.
    task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [1:0] size, input logic u);
        @(negedge clk);
        core_we = we; core_addr = addr; core_wdata = wd; core_size = size;
        core_unsigned = u; core_req = 1'b1;
        @(posedge clk);
        #1;
        core_req = 1'b0; core_addr = ~addr; core_wdata = ~wd; core_we = ~we;
        core_size = 2'b10; core_unsigned = ~u;
        r_cyc = 0; r_vc = 0; r_bhw = '0; r_uns = 1'b0;
        r_err = 'x; r_rdata = 'x; r_faddr = 'x;
        while (r_cyc < 200) begin
            @(negedge clk);
            r_cyc++;
            if (valid) begin r_vc++; r_bhw = bhw; r_uns = uns; end
            if (done) begin r_err = err; r_rdata = rdata; r_faddr = faddr; break; end
        end
        if (r_cyc >= 200) check("done_wait_bound", 32'(r_cyc), 32'd0);
    endtask

    int n_done;

    initial begin
        rst = 1'b1; sel = 1'b0; core_req = 1'b0; core_we = 1'b0;
        core_addr = '0; core_wdata = '0; core_size = '0; core_unsigned = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {busy, done, valid, rw, uns, err, bhw, rdata | faddr | maddr | mdin}, '0);
        @(negedge clk); rst = 1'b0;

        // Store word then load word.
        mode = 0; lat = 2;
        run_req(1'b1, 32'h0000941C, 32'h6A70A30C, 2'b00, 1'b0);
        check("st_err", 32'(r_err), 32'd0);
        check("st_valid_cycles", 32'(r_vc), 32'd2);
        check("st_rdata_zero", r_rdata, 32'h0);
        lat = 3;
        run_req(1'b0, 32'h0000941C, 32'h0, 2'b00, 1'b0);
        check("ld_err", 32'(r_err), 32'd0);
        check("ld_rdata", r_rdata, 32'h6A70A30C);
        check("ld_valid_cycles", 32'(r_vc), 32'd3);
        check("ld_latency", 32'(r_cyc), 32'd5);

        // Misaligned word load, alignment check on.
        lat = 1;
        run_req(1'b0, 32'h0000941B, 32'h0, 2'b00, 1'b0);
        check("mis_done_cycle", 32'(r_cyc), 32'd2);
        check("mis_err", 32'(r_err), 32'd1);
        check("mis_faddr", r_faddr, 32'h0000941B);
        check("mis_valid_cycles", 32'(r_vc), 32'd0);

        // Illegal size.
        run_req(1'b0, 32'h00009418, 32'h0, 2'b11, 1'b0);
        check("ill_err", 32'(r_err), 32'd1);
        check("ill_valid_cycles", 32'(r_vc), 32'd0);

        // Same misaligned load with alignment check off.
        sel = 1'b1;
        run_req(1'b0, 32'h0000941B, 32'h0, 2'b00, 1'b0);
        check("noalign_err", 32'(r_err), 32'd0);
        check("noalign_valid_cycles", 32'(r_vc), 32'd1);
        run_req(1'b0, 32'h00009418, 32'h0, 2'b11, 1'b0);
        check("noalign_ill_err", 32'(r_err), 32'd1);
        sel = 1'b0;

        // Access fault, alone and together with ready.
        mode = 2;
        run_req(1'b0, 32'h0000F45F, 32'h0, 2'b10, 1'b0);
        check("oor_err", 32'(r_err), 32'd2);
        mode = 3;
        run_req(1'b0, 32'h0000F45F, 32'h0, 2'b10, 1'b0);
        check("oor_rdy_err", 32'(r_err), 32'd2);
        check("oor_rdy_rdata", r_rdata, 32'h0);

        // Signed byte load.
        mode = 0; lat = 1; ovr_en = 1'b1; ovr_data = 32'hFFFFFFA3;
        run_req(1'b0, 32'h00009419, 32'h0, 2'b10, 1'b0);
        check("byte_bhw", 32'(r_bhw), 32'd2);
        check("byte_uns", 32'(r_uns), 32'd0);
        check("byte_rdata", r_rdata, 32'hFFFFFFA3);
        check("byte_err", 32'(r_err), 32'd0);
        ovr_en = 1'b0;

        // Timeout.
        mode = 1;
        run_req(1'b0, 32'h00009420, 32'h0, 2'b00, 1'b1);
        check("tmo_valid_cycles", 32'(r_vc), 32'd16);
        check("tmo_err", 32'(r_err), 32'd3);
        check("tmo_done_cycle", 32'(r_cyc), 32'd18);
        mode = 0;
        run_req(1'b0, 32'h0000941C, 32'h0, 2'b00, 1'b0);
        check("after_tmo_err", 32'(r_err), 32'd0);
        check("after_tmo_rdata", r_rdata, 32'h6A70A30C);

        // Reset during the third ACCESS cycle.
        mode = 1;
        @(negedge clk);
        core_we = 1'b1; core_addr = 32'h00009424; core_wdata = 32'h12345678;
        core_size = 2'b00; core_unsigned = 1'b1; core_req = 1'b1;
        @(posedge clk); #1 core_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mid_valid", 32'(valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_outputs", {busy, done, valid, rw, uns, err, bhw, rdata | faddr | maddr | mdin}, '0);
        @(negedge clk); rst = 1'b0;
        n_done = 0;
        repeat (6) begin @(negedge clk); if (done) n_done++; end
        check("rst_no_done", 32'(n_done), 32'd0);
        mode = 0; lat = 2;
        run_req(1'b0, 32'h0000941C, 32'h0, 2'b00, 1'b0);
        check("after_rst_err", 32'(r_err), 32'd0);
        check("after_rst_rdata", r_rdata, 32'h6A70A30C);

        check("min_valid_gap_ge2", 32'(min_gap >= 2), 32'd1);
        check("done_max_one_cycle", 32'(max_done_run), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store unit master that sits between the CPU execute stage and the `memory` block (cache plus main memory). It accepts one load or store request at a time from the core and drives the memory's valid/ready handshake. It checks RISC-V alignment before issuing, and returns load data or a classified error to the core. It also enforces the one-cycle valid-low gap the memory requires between transactions and aborts hung accesses with a timeout.

## Interface
- `TIMEOUT_CYCLES`, default 64: maximum cycles `mem_valid` may stay high waiting for a response; 0 disables the timeout.
- `ALIGN_CHECK`, default 1: 1 rejects misaligned half/word accesses; 0 passes them to memory unchanged.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `core_req` in 1: request strobe, sampled only while `core_busy`=0.
- `core_we` in 1: 1 = store, 0 = load.
- `core_addr` in 32: byte address.
- `core_wdata` in 32: store data; byte/half taken from the low bits.
- `core_size` in 2: 00 word, 01 halfword, 10 byte, 11 illegal. Same encoding as `byte_half_word`.
- `core_unsigned` in 1: zero-extend loads.
- `core_busy` out 1: high from request acceptance until `core_done`, inclusive.
- `core_done` out 1: one-cycle completion pulse.
- `core_rdata` out 32: load result, valid with `core_done`; 0 for stores and errors.
- `core_err` out 2: valid with `core_done`. 00 ok, 01 misaligned/illegal size, 10 access fault (`out_of_range`), 11 timeout.
- `core_fault_addr` out 32: address of the completed access, valid with `core_done`.
- `mem_valid` out 1; `mem_rw` out 1 (1 = write); `mem_addr` out 32; `mem_data_in` out 32; `mem_byte_half_word` out 2; `mem_is_load_unsigned` out 1.
- `mem_ready` in 1; `mem_out_of_range` in 1; `mem_data_out` in 32.

## Operation
- States:
  - IDLE: `core_busy`=0, `mem_valid`=0.
  - CHECK: one cycle; alignment/size decode.
  - ACCESS: `mem_valid`=1.
  - RELEASE: `mem_valid`=0, `core_done`=1.
- IDLE→CHECK on `core_req`. All `core_*` request fields are latched at that edge; later changes to the inputs are ignored.
- CHECK→RELEASE with `core_err`=01, and no memory access, when any of these holds:
  - `core_size`=11 (always, regardless of `ALIGN_CHECK`);
  - `ALIGN_CHECK`=1, size word, and `addr[1:0]`≠0;
  - `ALIGN_CHECK`=1, size half, and `addr[0]`≠0.
- Otherwise CHECK→ACCESS.
- In ACCESS, all `mem_*` request outputs are driven from the latched fields and stay stable for the whole state.
- ACCESS→RELEASE at the first edge that sees any of the following, in this priority order:
  - `mem_out_of_range`=1 → err 10;
  - `mem_ready`=1 → err 00, and `core_rdata` ← `mem_data_out` on loads;
  - timeout counter = `TIMEOUT_CYCLES`−1 → err 11.
- `mem_out_of_range` wins over a simultaneous `mem_ready`.
- RELEASE→IDLE unconditionally. A request presented during RELEASE is not accepted, because `core_busy`=1.
- Load data is forwarded unchanged; sign/zero extension is done by the memory from `mem_is_load_unsigned`.
- The timeout counter is 16 bits, clears on entry to ACCESS, and saturates (no wrap).

## Timing
- Reset values: state IDLE; all outputs 0 (`mem_valid`, `core_busy`, `core_done`, `core_rdata`, `core_err`, `core_fault_addr`, all `mem_*` fields).
- Reset mid-ACCESS: `mem_valid`=0 the cycle after `rst` is sampled; no `core_done` is issued for the aborted access.
- `core_req` sampled at edge E0: `core_busy`=1 from E0; CHECK during E0→E1; `mem_valid`=1 from E1.
- Memory response sampled at edge Ek: `mem_valid`=0 and `core_done`=1 during Ek→Ek+1; IDLE from Ek+1.
- Earliest next acceptance is at Ek+1, so `mem_valid` is low for at least two cycles (RELEASE, then CHECK) between accesses.
- Error path: `core_done` at E1→E2 with `mem_valid` never asserted.
- Timeout: `mem_valid` is high for exactly `TIMEOUT_CYCLES` cycles, then drops with err 11.
- `core_done` is never high for more than one cycle.

## Test plan
- Store word, then load word, both at 0x0000941C with data 0x6A70A30C. Required: each access completes err 00; the load returns `core_rdata`=0x6A70A30C; `mem_valid` is held until `mem_ready` and low for at least 2 cycles between the accesses.
- Word load at 0x0000941B with `ALIGN_CHECK`=1. Required: `core_done` 2 cycles after the request, err 01, `core_fault_addr`=0x0000941B, `mem_valid` never high. Repeat with `ALIGN_CHECK`=0: `mem_valid` asserted, err 00.
- Load at 0x0000F45F; memory model asserts `out_of_range`, in one run together with `ready`. Required: err 10 in both runs.
- Byte load, signed, at 0x00009419; memory model returns 0xFFFFFFA3. Required: `mem_byte_half_word`=10, `mem_is_load_unsigned`=0, `core_rdata`=0xFFFFFFA3.
- `TIMEOUT_CYCLES`=16 with a memory model that never responds. Required: `mem_valid` high exactly 16 cycles, then `core_done` with err 11; a following request is accepted normally.
- `rst` asserted during the 3rd ACCESS cycle. Required: next cycle all outputs are 0 and no `core_done` is issued; a new request afterwards completes err 00.
